// File: rtl/vga_scanout_engine.sv
// VGA scan-out engine: H/V timing, double-buffered linear framebuffer addressing and a 24-bit palette.
// Optional hardware cursor overlay is built when VGA_SCANOUT_CURSOR_EN is defined.
module vga_scanout_engine #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int PIX_W    = 8,
  parameter int ADDR_W   = 20,
  parameter int SYNC_POL = 0
) (
  input  logic              iVGA_CLK,
  input  logic              iRST_n,
  input  logic              iBUF_SEL,
  output logic              oBUF_ACTIVE,
  output logic [ADDR_W-1:0] oFB_ADDR,
  output logic              oFB_RD_EN,
  input  logic [PIX_W-1:0]  iFB_RDATA,
  input  logic              iPAL_WE,
  input  logic [PIX_W-1:0]  iPAL_ADDR,
  input  logic [23:0]       iPAL_DATA,
`ifdef VGA_SCANOUT_CURSOR_EN
  input  logic [10:0]       iCUR_X,
  input  logic [9:0]        iCUR_Y,
  input  logic [23:0]       iCUR_COLOR,
`endif
  output logic              oFRAME_START,
  output logic              oHS,
  output logic              oVS,
  output logic              oBLANK_n,
  output logic [7:0]        oR,
  output logic [7:0]        oG,
  output logic [7:0]        oB
);

  localparam int H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HCW       = $clog2(H_TOTAL + 1);
  localparam int VCW       = $clog2(V_TOTAL + 1);
  localparam int PAL_DEPTH = 1 << PIX_W;

  localparam logic [HCW-1:0] H_ACT  = HCW'(H_ACTIVE);
  localparam logic [HCW-1:0] H_HS0  = HCW'(H_ACTIVE + H_FP);
  localparam logic [HCW-1:0] H_HS1  = HCW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [HCW-1:0] H_LAST = HCW'(H_TOTAL - 1);
  localparam logic [VCW-1:0] V_ACT  = VCW'(V_ACTIVE);
  localparam logic [VCW-1:0] V_VS0  = VCW'(V_ACTIVE + V_FP);
  localparam logic [VCW-1:0] V_VS1  = VCW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VCW-1:0] V_LAST = VCW'(V_TOTAL - 1);

  localparam logic              POL   = (SYNC_POL != 0);
  localparam logic [ADDR_W-1:0] BASE1 = ADDR_W'(H_ACTIVE * V_ACTIVE);

  if (longint'(2) * H_ACTIVE * V_ACTIVE > (longint'(1) << ADDR_W)) begin : g_addr_w_too_small
    $error("vga_scanout_engine: ADDR_W cannot hold two frames of H_ACTIVE*V_ACTIVE pixels");
  end

  logic [HCW-1:0]    h_cnt_q, h_cnt_d;
  logic [VCW-1:0]    v_cnt_q, v_cnt_d;
  logic [ADDR_W-1:0] lin_q, lin_d;
  logic [ADDR_W-1:0] fb_addr_q, fb_addr_d;
  logic              rd_en_q, rd_en_d;
  logic              buf_q, buf_d;
  logic              hs1_q, hs1_d, vs1_q, vs1_d, fs1_q, fs1_d;
  logic              hs2_q, hs2_d, vs2_q, vs2_d, fs2_q, fs2_d, act2_q, act2_d;
  logic              hs3_q, hs3_d, vs3_q, vs3_d, fs3_q, fs3_d, blank3_q, blank3_d;
  logic [23:0]       rgb_q, rgb_d;

  logic              active, hs_raw, vs_raw, frame_first, swap_pt;
  logic [ADDR_W-1:0] lin_cur;
  logic [23:0]       pal_mem [PAL_DEPTH];

`ifdef VGA_SCANOUT_CURSOR_EN
  logic [10:0] cur_x_q, cur_x_d;
  logic [9:0]  cur_y_q, cur_y_d;
  logic [23:0] cur_color_q, cur_color_d;
  logic        cur1_q, cur1_d, cur2_q, cur2_d;
  logic [11:0] h_ext;
  logic [10:0] v_ext;
`endif

  // Palette RAM: synchronous write, read happens in the stage-3 register so a same-clock write shows the old entry.
  always_ff @(posedge iVGA_CLK) begin
    if (iPAL_WE) pal_mem[iPAL_ADDR] <= iPAL_DATA;
  end

  always_comb begin
    active      = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
    hs_raw      = (h_cnt_q >= H_HS0) && (h_cnt_q < H_HS1);
    vs_raw      = (v_cnt_q >= V_VS0) && (v_cnt_q < V_VS1);
    frame_first = (h_cnt_q == '0) && (v_cnt_q == '0);
    swap_pt     = (h_cnt_q == '0) && (v_cnt_q == V_ACT);

    h_cnt_d = (h_cnt_q == H_LAST) ? '0 : h_cnt_q + 1'b1;
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == H_LAST) v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;

    // The linear pixel count only restarts at the top-left pixel, so blanking never disturbs it.
    lin_cur   = frame_first ? '0 : lin_q;
    lin_d     = active ? lin_cur + 1'b1 : lin_cur;
    fb_addr_d = (buf_q ? BASE1 : '0) + lin_cur;
    rd_en_d   = active;
    buf_d     = swap_pt ? iBUF_SEL : buf_q;

    hs1_d    = hs_raw ? POL : ~POL;
    vs1_d    = vs_raw ? POL : ~POL;
    fs1_d    = frame_first;
    hs2_d    = hs1_q;
    vs2_d    = vs1_q;
    fs2_d    = fs1_q;
    act2_d   = rd_en_q;
    hs3_d    = hs2_q;
    vs3_d    = vs2_q;
    fs3_d    = fs2_q;
    blank3_d = act2_q;

    rgb_d = act2_q ? pal_mem[iFB_RDATA] : 24'h0;

`ifdef VGA_SCANOUT_CURSOR_EN
    h_ext       = 12'(h_cnt_q);
    v_ext       = 11'(v_cnt_q);
    cur_x_d     = swap_pt ? iCUR_X : cur_x_q;
    cur_y_d     = swap_pt ? iCUR_Y : cur_y_q;
    cur_color_d = swap_pt ? iCUR_COLOR : cur_color_q;
    cur1_d      = active &&
                  (h_ext >= {1'b0, cur_x_q}) && (h_ext < {1'b0, cur_x_q} + 12'd16) &&
                  (v_ext >= {1'b0, cur_y_q}) && (v_ext < {1'b0, cur_y_q} + 11'd16);
    cur2_d      = cur1_q;
    if (act2_q && cur2_q) rgb_d = cur_color_q;
`endif
  end

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      h_cnt_q   <= '0;
      v_cnt_q   <= '0;
      lin_q     <= '0;
      fb_addr_q <= '0;
      rd_en_q   <= 1'b0;
      buf_q     <= 1'b0;
      hs1_q     <= ~POL;
      vs1_q     <= ~POL;
      fs1_q     <= 1'b0;
      hs2_q     <= ~POL;
      vs2_q     <= ~POL;
      fs2_q     <= 1'b0;
      act2_q    <= 1'b0;
      hs3_q     <= ~POL;
      vs3_q     <= ~POL;
      fs3_q     <= 1'b0;
      blank3_q  <= 1'b0;
      rgb_q     <= '0;
    end else begin
      h_cnt_q   <= h_cnt_d;
      v_cnt_q   <= v_cnt_d;
      lin_q     <= lin_d;
      fb_addr_q <= fb_addr_d;
      rd_en_q   <= rd_en_d;
      buf_q     <= buf_d;
      hs1_q     <= hs1_d;
      vs1_q     <= vs1_d;
      fs1_q     <= fs1_d;
      hs2_q     <= hs2_d;
      vs2_q     <= vs2_d;
      fs2_q     <= fs2_d;
      act2_q    <= act2_d;
      hs3_q     <= hs3_d;
      vs3_q     <= vs3_d;
      fs3_q     <= fs3_d;
      blank3_q  <= blank3_d;
      rgb_q     <= rgb_d;
    end
  end

`ifdef VGA_SCANOUT_CURSOR_EN
  // Cursor X resets to all-ones so nothing is overlaid until the first sample is taken.
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      cur_x_q     <= '1;
      cur_y_q     <= '0;
      cur_color_q <= '0;
      cur1_q      <= 1'b0;
      cur2_q      <= 1'b0;
    end else begin
      cur_x_q     <= cur_x_d;
      cur_y_q     <= cur_y_d;
      cur_color_q <= cur_color_d;
      cur1_q      <= cur1_d;
      cur2_q      <= cur2_d;
    end
  end
`endif

  assign oBUF_ACTIVE  = buf_q;
  assign oFB_ADDR     = fb_addr_q;
  assign oFB_RD_EN    = rd_en_q;
  assign oFRAME_START = fs3_q;
  assign oHS          = hs3_q;
  assign oVS          = vs3_q;
  assign oBLANK_n     = blank3_q;
  assign oR           = rgb_q[7:0];
  assign oG           = rgb_q[15:8];
  assign oB           = rgb_q[23:16];

endmodule

// File: tb/tb_vga_scanout_engine.sv
// Testbench for vga_scanout_engine on a tiny 8x4 raster (14-clock lines, 7-line frames).
// Cursor checks are built only when VGA_SCANOUT_CURSOR_EN is defined.
module tb_vga_scanout_engine;

  localparam int HT = 14;
  localparam int VT = 7;
  localparam int FRAME = HT * VT;

  logic        iVGA_CLK = 1'b0;
  logic        iRST_n;
  logic        iBUF_SEL;
  logic        oBUF_ACTIVE;
  logic [7:0]  oFB_ADDR;
  logic        oFB_RD_EN;
  logic [3:0]  iFB_RDATA;
  logic        iPAL_WE;
  logic [3:0]  iPAL_ADDR;
  logic [23:0] iPAL_DATA;
  logic        oFRAME_START, oHS, oVS, oBLANK_n;
  logic [7:0]  oR, oG, oB;
`ifdef VGA_SCANOUT_CURSOR_EN
  logic [10:0] iCUR_X;
  logic [9:0]  iCUR_Y;
  logic [23:0] iCUR_COLOR;
`endif

  vga_scanout_engine #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .PIX_W(4), .ADDR_W(8), .SYNC_POL(0)
  ) dut (
    .iVGA_CLK(iVGA_CLK), .iRST_n(iRST_n), .iBUF_SEL(iBUF_SEL), .oBUF_ACTIVE(oBUF_ACTIVE),
    .oFB_ADDR(oFB_ADDR), .oFB_RD_EN(oFB_RD_EN), .iFB_RDATA(iFB_RDATA),
    .iPAL_WE(iPAL_WE), .iPAL_ADDR(iPAL_ADDR), .iPAL_DATA(iPAL_DATA),
`ifdef VGA_SCANOUT_CURSOR_EN
    .iCUR_X(iCUR_X), .iCUR_Y(iCUR_Y), .iCUR_COLOR(iCUR_COLOR),
`endif
    .oFRAME_START(oFRAME_START), .oHS(oHS), .oVS(oVS), .oBLANK_n(oBLANK_n),
    .oR(oR), .oG(oG), .oB(oB)
  );

  always #5 iVGA_CLK = ~iVGA_CLK;

  // Framebuffer model: one-clock read latency, each word holds the low nibble of its address.
  always @(posedge iVGA_CLK) iFB_RDATA <= oFB_ADDR[3:0];

  int tests = 0;
  int fails = 0;
  int n_edges = 0;
  int blank_cnt = 0, fs_cnt = 0, rd_cnt = 0;
  int amin = 9999, amax = 0;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        blank;
    logic        fs;
    logic        cur;
    logic [3:0]  idx;
    logic [23:0] ccol;
  } exp_t;

  exp_t        sb[$];
  logic [23:0] pal_m [16];
  logic        buf_m = 1'b0;
  int          cx_m = 2047, cy_m = 0;
  logic [23:0] ccol_m = 24'h0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic checkResetState(input string phase);
    checkOutput({phase, "_addr"}, 32'(oFB_ADDR), 32'h0);
    checkOutput({phase, "_rden"}, 32'(oFB_RD_EN), 32'h0);
    checkOutput({phase, "_blank"}, 32'(oBLANK_n), 32'h0);
    checkOutput({phase, "_rgb"}, 32'({oB, oG, oR}), 32'h0);
    checkOutput({phase, "_fs"}, 32'(oFRAME_START), 32'h0);
    checkOutput({phase, "_hs"}, 32'(oHS), 32'h1);
    checkOutput({phase, "_vs"}, 32'(oVS), 32'h1);
    checkOutput({phase, "_buf"}, 32'(oBUF_ACTIVE), 32'h0);
  endtask

  // One palette write, driven from a negedge and held for exactly one rising edge.
  task automatic applyStimulus(input logic [3:0] a, input logic [23:0] d);
    iPAL_WE = 1'b1;
    iPAL_ADDR = a;
    iPAL_DATA = d;
    @(negedge iVGA_CLK);
    iPAL_WE = 1'b0;
  endtask

  task automatic waitEdge(input int target);
    int guard = 0;
    while (n_edges < target && guard < 2000) begin
      @(negedge iVGA_CLK);
      guard++;
    end
    if (n_edges < target) checkOutput("wait_timeout", 32'(n_edges), 32'(target));
  endtask

  // Scoreboard: expected pixel pushed when its counter value is decoded, popped when it reaches the pins.
  always @(posedge iVGA_CLK) begin : monitor
    logic        rst_s, sel_s, we_s;
    logic [3:0]  pa_s;
    logic [23:0] pd_s, col;
    int          c, h, v;
    logic        act;
    exp_t        e, p;
`ifdef VGA_SCANOUT_CURSOR_EN
    int          cxs, cys;
    logic [23:0] ccs;
    cxs = int'(iCUR_X);
    cys = int'(iCUR_Y);
    ccs = iCUR_COLOR;
`endif
    rst_s = iRST_n;
    sel_s = iBUF_SEL;
    we_s  = iPAL_WE;
    pa_s  = iPAL_ADDR;
    pd_s  = iPAL_DATA;
    #1;
    if (!rst_s) begin
      sb.delete();
      n_edges = 0;
      buf_m = 1'b0;
      cx_m = 2047;
      cy_m = 0;
      ccol_m = 24'h0;
    end else begin
      n_edges++;
      c = n_edges - 1;
      h = c % HT;
      v = (c / HT) % VT;
      act = (h < 8) && (v < 4);
      e.hs    = (h >= 10 && h < 12) ? 1'b0 : 1'b1;
      e.vs    = (v == 5) ? 1'b0 : 1'b1;
      e.blank = act;
      e.fs    = (h == 0 && v == 0);
      e.idx   = 4'((v * 8 + h) % 16);
      e.cur   = act && (h >= cx_m) && (h < cx_m + 16) && (v >= cy_m) && (v < cy_m + 16);
      e.ccol  = ccol_m;
      checkOutput("rd_en", 32'(oFB_RD_EN), 32'(act));
      if (act) checkOutput("fb_addr", 32'(oFB_ADDR), 32'((buf_m ? 32 : 0) + v * 8 + h));
      if (h == 0 && v == 4) begin
        buf_m = sel_s;
`ifdef VGA_SCANOUT_CURSOR_EN
        cx_m = cxs;
        cy_m = cys;
        ccol_m = ccs;
`endif
      end
      checkOutput("buf_active", 32'(oBUF_ACTIVE), 32'(buf_m));
      sb.push_back(e);
      if (sb.size() == 3) begin
        p = sb.pop_front();
        col = !p.blank ? 24'h0 : (p.cur ? p.ccol : pal_m[p.idx]);
        checkOutput("hs", 32'(oHS), 32'(p.hs));
        checkOutput("vs", 32'(oVS), 32'(p.vs));
        checkOutput("blank_n", 32'(oBLANK_n), 32'(p.blank));
        checkOutput("frame_start", 32'(oFRAME_START), 32'(p.fs));
        checkOutput("rgb", 32'({oB, oG, oR}), 32'(col));
      end else begin
        checkOutput("fill_blank_n", 32'(oBLANK_n), 32'h0);
        checkOutput("fill_hs", 32'(oHS), 32'h1);
        checkOutput("fill_rgb", 32'({oB, oG, oR}), 32'h0);
      end
      if (oBLANK_n) blank_cnt++;
      if (oFRAME_START) fs_cnt++;
      if (oFB_RD_EN) begin
        rd_cnt++;
        if (int'(oFB_ADDR) < amin) amin = int'(oFB_ADDR);
        if (int'(oFB_ADDR) > amax) amax = int'(oFB_ADDR);
      end
    end
    if (we_s) pal_m[pa_s] = pd_s;
  end

  initial begin
    iRST_n = 1'b0;
    iBUF_SEL = 1'b0;
    iPAL_WE = 1'b0;
    iPAL_ADDR = 4'h0;
    iPAL_DATA = 24'h0;
`ifdef VGA_SCANOUT_CURSOR_EN
    iCUR_X = 11'd6;
    iCUR_Y = 10'd2;
    iCUR_COLOR = 24'hFFFFFF;
`endif
    repeat (2) @(negedge iVGA_CLK);
    checkResetState("por");
    for (int i = 0; i < 16; i++) applyStimulus(4'(i), {16'h0, 8'(i * 16)});

    blank_cnt = 0; fs_cnt = 0; rd_cnt = 0;
    iRST_n = 1'b1;

    waitEdge(2 * FRAME);
    checkOutput("two_frame_blank_cnt", 32'(blank_cnt), 32'd64);
    checkOutput("two_frame_fs_cnt", 32'(fs_cnt), 32'd2);
    checkOutput("two_frame_rd_cnt", 32'(rd_cnt), 32'd64);

    waitEdge(2 * FRAME + 20);
    iBUF_SEL = 1'b1;
    checkOutput("buf_mid_frame", 32'(oBUF_ACTIVE), 32'h0);
    waitEdge(2 * FRAME + 4 * HT);
    checkOutput("buf_before_swap", 32'(oBUF_ACTIVE), 32'h0);
    waitEdge(2 * FRAME + 4 * HT + 1);
    checkOutput("buf_after_swap", 32'(oBUF_ACTIVE), 32'h1);
    waitEdge(3 * FRAME);
    amin = 9999; amax = 0;
    waitEdge(4 * FRAME);
    checkOutput("buf1_addr_min", 32'(amin), 32'd32);
    checkOutput("buf1_addr_max", 32'(amax), 32'd63);

    waitEdge(4 * FRAME + 3 + 2);
    applyStimulus(4'h3, 24'hABCDEF);
    checkOutput("pal_collide_old", 32'({oB, oG, oR}), 32'h000030);
    waitEdge(4 * FRAME + 2 * HT + 3 + 3);
    checkOutput("pal_new_entry", 32'({oB, oG, oR}), 32'hABCDEF);

    waitEdge(5 * FRAME + 2 * HT + 5);
    iRST_n = 1'b0;
    #1;
    checkResetState("mid_rst");
    repeat (2) @(negedge iVGA_CLK);
    blank_cnt = 0; fs_cnt = 0; rd_cnt = 0;
    iRST_n = 1'b1;
    waitEdge(1);
    checkOutput("restart_addr", 32'(oFB_ADDR), 32'h0);
    checkOutput("restart_rden", 32'(oFB_RD_EN), 32'h1);
    waitEdge(FRAME);
    checkOutput("restart_rd_cnt", 32'(rd_cnt), 32'd32);
    checkOutput("restart_blank_cnt", 32'(blank_cnt), 32'd32);
    checkOutput("restart_fs_cnt", 32'(fs_cnt), 32'd1);

`ifdef VGA_SCANOUT_CURSOR_EN
    waitEdge(FRAME + 2 * HT + 5 + 3);
    checkOutput("cursor_left_edge", 32'({oB, oG, oR}), 32'h000050);
    waitEdge(FRAME + 2 * HT + 6 + 3);
    checkOutput("cursor_on", 32'({oB, oG, oR}), 32'hFFFFFF);
    waitEdge(FRAME + 3 * HT + 7 + 3);
    checkOutput("cursor_clip_corner", 32'({oB, oG, oR}), 32'hFFFFFF);
`endif

    waitEdge(2 * FRAME + 10);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
